// File: rtl/conclover_sequencer.sv
// Run sequencer for the conclover correlator: fetch samples, shift the window, write MAC results. Optional abort port: CONCLOVER_SEQ_ABORT_EN.
// One sample in flight at a time; both masters hold address/data while waitrequest is high, results wait MAC_LAT cycles after shift_en.
module conclover_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TAPS    = 20,
    parameter int MAC_LAT = 2,
    parameter int ACC_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] read_start_addr,
    input  logic [ADDR_W-1:0] read_stop_addr,
    input  logic [ADDR_W-1:0] write_start_addr,
    input  logic [ADDR_W-1:0] write_stop_addr,
    output logic              work,
    output logic              done,
    output logic              rd_read,
    output logic [ADDR_W-1:0] rd_address,
    input  logic              rd_waitrequest,
    input  logic              rd_readdatavalid,
    input  logic [7:0]        rd_readdata,
    output logic              shift_en,
    output logic [7:0]        sample_out,
    output logic              clr_window,
    input  logic [ACC_W-1:0]  mac_result,
    output logic              wr_write,
    output logic [ADDR_W-1:0] wr_address,
    output logic [31:0]       wr_writedata,
`ifdef CONCLOVER_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              wr_waitrequest
);

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int LAT_W = $clog2(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] TAPS_M1 = CNT_W'(TAPS - 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAC_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_SHIFT, S_COMPUTE, S_WR, S_NEXT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, rd_stop_q, rd_stop_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_stop_q, wr_stop_d;
    logic              wr_empty_q, wr_empty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [7:0]        sample_q, sample_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              clr_q, clr_d;
    logic              work_q;
    logic              abort_pend;
    logic              rd_last, wr_last, filling;

    assign rd_last = (rd_ptr_q == rd_stop_q);
    // An inverted write window still takes exactly one result, then ends the run.
    assign wr_last = (wr_ptr_q == wr_stop_q) || wr_empty_q;
    assign filling = (cnt_q < TAPS_M1);

`ifdef CONCLOVER_SEQ_ABORT_EN
    logic abort_q;
    assign abort_pend = abort | abort_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) abort_q <= 1'b0;
        else     abort_q <= (state_q != S_IDLE) && (state_d != S_IDLE) && abort_pend;
    end
`else
    assign abort_pend = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (read_stop_addr < read_start_addr) ? S_DONE : S_RD_REQ;
            S_RD_REQ:  if (!rd_waitrequest) state_d = S_RD_WAIT;
            S_RD_WAIT: if (rd_readdatavalid) state_d = abort_pend ? S_IDLE : S_SHIFT;
            S_SHIFT:   state_d = abort_pend ? S_IDLE : (filling ? S_NEXT : S_COMPUTE);
            S_COMPUTE: begin
                if (abort_pend)           state_d = S_IDLE;
                else if (lat_q == LAT_MAX) state_d = S_WR;
            end
            S_WR:      if (!wr_waitrequest) state_d = abort_pend ? S_IDLE : (wr_last ? S_DONE : S_NEXT);
            S_NEXT:    state_d = abort_pend ? S_IDLE : (rd_last ? S_DONE : S_RD_REQ);
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_read  = (state_q == S_RD_REQ);
        shift_en = (state_q == S_SHIFT);
        wr_write = (state_q == S_WR);
        done     = (state_q == S_DONE) && !abort_pend;
    end

    assign work         = work_q;
    assign clr_window   = clr_q;
    assign rd_address   = rd_ptr_q;
    assign wr_address   = wr_ptr_q;
    assign wr_writedata = wdata_q;
    assign sample_out   = sample_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        rd_stop_d  = rd_stop_q;
        wr_ptr_d   = wr_ptr_q;
        wr_stop_d  = wr_stop_q;
        wr_empty_d = wr_empty_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        sample_d   = sample_q;
        wdata_d    = wdata_q;
        clr_d      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                rd_ptr_d   = read_start_addr;
                rd_stop_d  = read_stop_addr;
                wr_ptr_d   = write_start_addr;
                wr_stop_d  = write_stop_addr;
                wr_empty_d = (write_stop_addr < write_start_addr);
                cnt_d      = '0;
                clr_d      = 1'b1;
            end
            S_RD_WAIT: if (rd_readdatavalid) sample_d = rd_readdata;
            S_SHIFT: begin
                if (filling) cnt_d = cnt_q + 1'b1;
                lat_d = LAT_W'(1);
            end
            S_COMPUTE: begin
                if (lat_q == LAT_MAX) wdata_d = 32'($signed(mac_result));
                else                  lat_d   = lat_q + 1'b1;
            end
            S_WR:   if (!wr_waitrequest && !wr_last) wr_ptr_d = wr_ptr_q + 1'b1;
            // Stop compare happens before the increment, so a stop of all-ones never wraps.
            S_NEXT: if (!rd_last) rd_ptr_d = rd_ptr_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rd_stop_q  <= '0;
            wr_ptr_q   <= '0;
            wr_stop_q  <= '0;
            wr_empty_q <= 1'b0;
            cnt_q      <= '0;
            lat_q      <= '0;
            sample_q   <= '0;
            wdata_q    <= '0;
            clr_q      <= 1'b0;
            work_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_stop_q  <= rd_stop_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_stop_q  <= wr_stop_d;
            wr_empty_q <= wr_empty_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            sample_q   <= sample_d;
            wdata_q    <= wdata_d;
            clr_q      <= clr_d;
            work_q     <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_conclover_sequencer.sv
// Bench for conclover_sequencer: Avalon slave models, a datapath stub with exact MAC latency, and a run-level reference model.
module tb_conclover_sequencer;
    localparam int ADDR_W  = 16;
    localparam int TAPS    = 20;
    localparam int MAC_LAT = 2;
    localparam int ACC_W   = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] read_start_addr = '0, read_stop_addr = '0;
    logic [ADDR_W-1:0] write_start_addr = '0, write_stop_addr = '0;
    logic              work, done, rd_read, shift_en, clr_window, wr_write;
    logic [ADDR_W-1:0] rd_address, wr_address;
    logic              rd_waitrequest = 1'b0, rd_readdatavalid = 1'b0, wr_waitrequest = 1'b0;
    logic [7:0]        rd_readdata = '0, sample_out;
    logic [ACC_W-1:0]  mac_result = '0;
    logic [31:0]       wr_writedata;

    conclover_sequencer #(.ADDR_W(ADDR_W), .TAPS(TAPS), .MAC_LAT(MAC_LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .read_start_addr(read_start_addr), .read_stop_addr(read_stop_addr),
        .write_start_addr(write_start_addr), .write_stop_addr(write_stop_addr),
        .work(work), .done(done),
        .rd_read(rd_read), .rd_address(rd_address), .rd_waitrequest(rd_waitrequest),
        .rd_readdatavalid(rd_readdatavalid), .rd_readdata(rd_readdata),
        .shift_en(shift_en), .sample_out(sample_out), .clr_window(clr_window),
        .mac_result(mac_result),
        .wr_write(wr_write), .wr_address(wr_address), .wr_writedata(wr_writedata),
        .wr_waitrequest(wr_waitrequest)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [7:0] mem [0:65535];
    int stall_mode = 0;   // 0 none, 1 random, 2 fixed (read 3, write 4)

    // slave / datapath model state
    int               rd_stall_left = -1, wr_stall_left = -1, rd_lat = 0, cd = -1;
    bit               rd_pending = 0, rd_prev_wait = 0, wr_prev_wait = 0, prev_done = 0;
    logic [15:0]      rd_pend_addr = '0, rd_prev_addr = '0, wr_prev_addr = '0;
    logic [31:0]      wr_prev_data = '0;
    int               pend = 0;
    logic signed [7:0] win[$];
    logic [15:0]      obs_raddr[$], obs_waddr[$];
    logic [31:0]      obs_wdata[$];
    int               shifts = 0, clr_cnt = 0, done_cnt = 0, work_cyc = 0;

    function automatic int weight(int p);
        return p - 7;
    endfunction

    function automatic int corr_win();
        int s = 0;
        for (int p = 0; p < win.size(); p++) s += int'(win[win.size()-1-p]) * weight(p);
        return s;
    endfunction

    function automatic int ref_corr(int rs, int k);
        int s = 0;
        for (int p = 0; p < TAPS; p++) s += int'($signed(mem[(rs + k - p) & 16'hFFFF])) * weight(p);
        return s;
    endfunction

    task automatic reset_models();
        rd_stall_left = -1; wr_stall_left = -1; rd_pending = 0; cd = -1;
        rd_prev_wait = 0; wr_prev_wait = 0; prev_done = 0;
    endtask

    task automatic clear_obs();
        obs_raddr.delete(); obs_waddr.delete(); obs_wdata.delete(); win.delete();
        shifts = 0; clr_cnt = 0; done_cnt = 0; work_cyc = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            // read slave
            rd_readdatavalid = 1'b0;
            rd_readdata = 8'($urandom);
            if (rd_pending) begin
                if (rd_lat == 0) begin
                    rd_readdatavalid = 1'b1;
                    rd_readdata = mem[rd_pend_addr];
                    rd_pending = 0;
                end else rd_lat--;
            end
            if (rd_read) begin
                if (rd_prev_wait) check("rd_address_hold", 32'(rd_address), 32'(rd_prev_addr));
                if (rd_stall_left < 0)
                    rd_stall_left = (stall_mode == 2) ? 3 : (stall_mode == 1) ? int'($urandom_range(0, 2)) : 0;
                if (rd_stall_left > 0) begin
                    rd_waitrequest = 1'b1; rd_stall_left--; rd_prev_wait = 1; rd_prev_addr = rd_address;
                end else begin
                    rd_waitrequest = 1'b0; rd_stall_left = -1; rd_prev_wait = 0;
                    obs_raddr.push_back(rd_address);
                    rd_pending = 1; rd_pend_addr = rd_address;
                    rd_lat = (stall_mode == 0) ? 0 : int'($urandom_range(0, 2));
                end
            end else begin
                rd_waitrequest = 1'($urandom_range(0, 1)); rd_prev_wait = 0;
            end
            // write slave
            if (wr_write) begin
                if (wr_prev_wait) begin
                    check("wr_address_hold", 32'(wr_address), 32'(wr_prev_addr));
                    check("wr_writedata_hold", wr_writedata, wr_prev_data);
                end
                if (wr_stall_left < 0)
                    wr_stall_left = (stall_mode == 2) ? 4 : (stall_mode == 1) ? int'($urandom_range(0, 3)) : 0;
                if (wr_stall_left > 0) begin
                    wr_waitrequest = 1'b1; wr_stall_left--; wr_prev_wait = 1;
                    wr_prev_addr = wr_address; wr_prev_data = wr_writedata;
                end else begin
                    wr_waitrequest = 1'b0; wr_stall_left = -1; wr_prev_wait = 0;
                    obs_waddr.push_back(wr_address); obs_wdata.push_back(wr_writedata);
                end
            end else begin
                wr_waitrequest = 1'($urandom_range(0, 1)); wr_prev_wait = 0;
            end
            // datapath stub: result is valid only in the MAC_LAT-th cycle after shift_en
            if (clr_window) begin win.delete(); clr_cnt++; end
            if (cd >= 0) cd--;
            if (shift_en) begin
                shifts++;
                win.push_back(sample_out);
                if (win.size() > TAPS) void'(win.pop_front());
                pend = corr_win();
                cd = MAC_LAT;
            end
            mac_result = (cd == 0) ? pend[ACC_W-1:0] : ACC_W'($urandom);
            // run-level monitor
            if (work) work_cyc++;
            if (prev_done) check("work_falls_after_done", 32'(work), 32'd0);
            if (done) begin
                done_cnt++;
                check("work_high_at_done", 32'(work), 32'd1);
            end
            prev_done = done;
        end
    end

    typedef struct {
        logic [15:0] rs, re, ws, we;
        int          mode;
        int          exp_r, exp_w;   // -1: take from reference model
        bit          poke;
    } vec_t;

    task automatic run(input vec_t v, input string tag);
        int rs, re, ws, we, n, nw, nr, er, ew, cyc;
        rs = int'(v.rs); re = int'(v.re); ws = int'(v.ws); we = int'(v.we);
        n = (re >= rs) ? re - rs + 1 : 0;
        if (n < TAPS)     nw = 0;
        else if (we >= ws) nw = (n - TAPS + 1 < we - ws + 1) ? n - TAPS + 1 : we - ws + 1;
        else              nw = 1;
        nr = (n >= TAPS && nw < n - TAPS + 1) ? TAPS + nw - 1 : n;
        er = (v.exp_r >= 0) ? v.exp_r : nr;
        ew = (v.exp_w >= 0) ? v.exp_w : nw;
        stall_mode = v.mode;
        @(posedge clk); #1;
        clear_obs();
        read_start_addr = v.rs; read_stop_addr = v.re;
        write_start_addr = v.ws; write_stop_addr = v.we;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            if (v.poke && cyc == 40) begin
                start = 1'b1;
                read_start_addr = 16'($urandom); read_stop_addr = 16'($urandom);
                write_start_addr = 16'($urandom); write_stop_addr = 16'($urandom);
            end else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_reads"}, 32'(obs_raddr.size()), 32'(er));
        check({tag, "_shifts"}, 32'(shifts), 32'(er));
        check({tag, "_writes"}, 32'(obs_waddr.size()), 32'(ew));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_clr_pulses"}, 32'(clr_cnt), 32'd1);
        if (n == 0) check({tag, "_work_cycles"}, 32'(work_cyc), 32'd1);
        for (int k = 0; k < obs_raddr.size() && k < nr; k++)
            check($sformatf("%s_raddr%0d", tag, k), 32'(obs_raddr[k]), 32'((rs + k) & 16'hFFFF));
        for (int i = 0; i < obs_waddr.size() && i < nw; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 32'(obs_waddr[i]), 32'((ws + i) & 16'hFFFF));
            check($sformatf("%s_wdata%0d", tag, i), obs_wdata[i], 32'(ref_corr(rs, TAPS - 1 + i)));
        end
    endtask

    vec_t tbl[9];

    initial begin
        int cyc;
        vec_t rv;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        tbl[0] = '{16'h0000, 16'h0018, 16'h0100, 16'h01FF, 0, 25, 6, 1'b0};
        tbl[1] = '{16'h0000, 16'h0009, 16'h0100, 16'h01FF, 0, 10, 0, 1'b0};
        tbl[2] = '{16'h0010, 16'h000F, 16'h0100, 16'h01FF, 0,  0, 0, 1'b0};
        tbl[3] = '{16'h0000, 16'h0027, 16'h0200, 16'h0204, 1, 24, 5, 1'b0};
        tbl[4] = '{16'h0000, 16'h001E, 16'h0300, 16'h02FF, 1, 20, 1, 1'b0};
        tbl[5] = '{16'hFFEA, 16'hFFFF, 16'h0010, 16'h0020, 1, 22, 3, 1'b0};
        tbl[6] = '{16'h0005, 16'h0005, 16'h0000, 16'h0005, 0,  1, 0, 1'b0};
        tbl[7] = '{16'h0040, 16'h0053, 16'h0400, 16'h0400, 2, 20, 1, 1'b1};
        tbl[8] = '{16'h0000, 16'h0018, 16'h0100, 16'h01FF, 2, 25, 6, 1'b1};

        #2;
        check("rst_work", 32'(work), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_read", 32'(rd_read), 32'd0);
        check("rst_wr_write", 32'(wr_write), 32'd0);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_clr_window", 32'(clr_window), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("tbl%0d", i));

        // async reset in the middle of a stalled write
        stall_mode = 2;
        clear_obs();
        read_start_addr = 16'h0000; read_stop_addr = 16'h0018;
        write_start_addr = 16'h0100; write_stop_addr = 16'h01FF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!wr_write && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        check("rstwr_reached_wr", 32'(wr_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstwr_work", 32'(work), 32'd0);
        check("rstwr_wr_write", 32'(wr_write), 32'd0);
        check("rstwr_wr_address", 32'(wr_address), 32'd0);
        check("rstwr_wr_writedata", wr_writedata, 32'd0);
        check("rstwr_rd_read", 32'(rd_read), 32'd0);
        check("rstwr_rd_address", 32'(rd_address), 32'd0);
        check("rstwr_sample_out", 32'(sample_out), 32'd0);
        check("rstwr_shift_en", 32'(shift_en), 32'd0);
        check("rstwr_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_models();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstwr_no_done", 32'(done_cnt), 32'd0);
        check("rstwr_idle_work", 32'(work), 32'd0);
        run(tbl[0], "after_rst");

        for (int i = 0; i < 6; i++) begin
            int len, wlen;
            len  = int'($urandom_range(0, 45));
            wlen = int'($urandom_range(0, 8));
            rv.rs = 16'($urandom_range(0, 300));
            rv.re = 16'(int'(rv.rs) + len - 1);
            rv.ws = 16'($urandom_range(16, 60000));
            rv.we = 16'(int'(rv.ws) + wlen - 1);
            rv.mode = int'($urandom_range(0, 1));
            rv.exp_r = -1; rv.exp_w = -1; rv.poke = 1'b0;
            run(rv, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
